// File: rtl/ram_dp_bwe.sv
// Dual-port SRAM model: port 0 read/write with byte enables, port 1 read-only.
// A clear sweep after reset zeroes the array. Define RAM256_PARITY_EN for per-byte parity and error flags.
module ram_dp_bwe #(
  parameter int  COLS    = 1,
  parameter int  WSIZE   = 4,
  parameter int  RD_PIPE = 0,
  localparam int A_WIDTH = 8 + $clog2(COLS),
  localparam int DW      = 8 * WSIZE
) (
  input  logic               CLK,
  input  logic               RST_N,
  output logic               READY,
  input  logic               EN0,
  input  logic [WSIZE-1:0]   WE0,
  input  logic [A_WIDTH-1:0] A0,
  input  logic [DW-1:0]      Di0,
  output logic [DW-1:0]      Do0,
  input  logic               EN1,
  input  logic [A_WIDTH-1:0] A1,
  output logic [DW-1:0]      Do1,
  output logic               ERR0,
  output logic               ERR1
);

  localparam int                 DEPTH     = 256 * COLS;
  localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] cnt_q, cnt_d;

  logic [A_WIDTH-1:0] wr_addr;
  logic [WSIZE-1:0]   wr_be;
  logic [DW-1:0]      wr_data;
  logic               rd0_en, rd1_en;
  logic               a0_ok, a1_ok;

  // Only a non-power-of-two bank count leaves unmapped addresses.
  generate
    if (DEPTH == (1 << A_WIDTH)) begin : g_pow2
      assign a0_ok = 1'b1;
      assign a1_ok = 1'b1;
    end else begin : g_npow2
      assign a0_ok = (32'(A0) < DEPTH);
      assign a1_ok = (32'(A1) < DEPTH);
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_addr = A0;
    wr_be   = '0;
    wr_data = Di0;
    rd0_en  = 1'b0;
    rd1_en  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        wr_addr = cnt_q;
        wr_be   = '1;
        wr_data = '0;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        rd0_en = EN0 & a0_ok;
        rd1_en = EN1 & a1_ok;
        wr_be  = (EN0 & a0_ok) ? WE0 : '0;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign READY = (state_q == ST_RUN);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd0_word, rd1_word;
  logic          rd0_perr, rd1_perr;

  assign rd0_word = mem_q[A0];
  assign rd1_word = mem_q[A1];

`ifdef RAM256_PARITY_EN
  logic [WSIZE-1:0] par_q [DEPTH];
  logic [WSIZE-1:0] wr_par;
  logic [WSIZE-1:0] rd0_par, rd1_par;
  logic [WSIZE-1:0] rd0_bad, rd1_bad;

  assign rd0_par = par_q[A0];
  assign rd1_par = par_q[A1];

  // Even parity: stored bit equals the XOR of its byte, so byte+bit XOR to 0 when intact.
  for (genvar gi = 0; gi < WSIZE; gi++) begin : g_par
    assign wr_par[gi]  = ^wr_data[gi*8 +: 8];
    assign rd0_bad[gi] = ^{rd0_word[gi*8 +: 8], rd0_par[gi]};
    assign rd1_bad[gi] = ^{rd1_word[gi*8 +: 8], rd1_par[gi]};
  end

  assign rd0_perr = |rd0_bad;
  assign rd1_perr = |rd1_bad;

  always_ff @(posedge CLK) begin
    for (int b = 0; b < WSIZE; b++) begin
      if (wr_be[b]) begin
        par_q[wr_addr][b] <= wr_par[b];
      end
    end
  end
`else
  assign rd0_perr = 1'b0;
  assign rd1_perr = 1'b0;
`endif

  // Array has no reset; the clear sweep is what initialises it.
  always_ff @(posedge CLK) begin
    for (int b = 0; b < WSIZE; b++) begin
      if (wr_be[b]) begin
        mem_q[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  logic [DW-1:0] s0_do0_q, s0_do1_q;
  logic          s0_err0_q, s0_err1_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s0_do0_q  <= '0;
      s0_do1_q  <= '0;
      s0_err0_q <= 1'b0;
      s0_err1_q <= 1'b0;
    end else begin
      s0_do0_q  <= rd0_en ? rd0_word : '0;
      s0_do1_q  <= rd1_en ? rd1_word : '0;
      s0_err0_q <= rd0_en & rd0_perr;
      s0_err1_q <= rd1_en & rd1_perr;
    end
  end

  generate
    if (RD_PIPE != 0) begin : g_pipe
      logic [DW-1:0] s1_do0_q, s1_do1_q;
      logic          s1_err0_q, s1_err1_q;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          s1_do0_q  <= '0;
          s1_do1_q  <= '0;
          s1_err0_q <= 1'b0;
          s1_err1_q <= 1'b0;
        end else begin
          s1_do0_q  <= s0_do0_q;
          s1_do1_q  <= s0_do1_q;
          s1_err0_q <= s0_err0_q;
          s1_err1_q <= s0_err1_q;
        end
      end

      assign Do0  = s1_do0_q;
      assign Do1  = s1_do1_q;
      assign ERR0 = s1_err0_q;
      assign ERR1 = s1_err1_q;
    end else begin : g_nopipe
      assign Do0  = s0_do0_q;
      assign Do1  = s0_do1_q;
      assign ERR0 = s0_err0_q;
      assign ERR1 = s0_err1_q;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_bwe.sv
// Scoreboard bench for ram_dp_bwe: one latency-1 and one latency-2 instance share stimulus.
// Parity corruption checks are compiled in when RAM256_PARITY_EN is defined.
module tb_ram_dp_bwe;

  localparam int DEPTH = 256;

  logic        CLK;
  logic        RST_N;
  logic        EN0, EN1;
  logic [3:0]  WE0;
  logic [7:0]  A0, A1;
  logic [31:0] Di0;

  logic        u0_ready, u0_err0, u0_err1;
  logic [31:0] u0_do0, u0_do1;
  logic        u1_ready, u1_err0, u1_err1;
  logic [31:0] u1_do0, u1_do1;

  ram_dp_bwe #(.COLS(1), .WSIZE(4), .RD_PIPE(0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .READY(u0_ready),
    .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(u0_do0),
    .EN1(EN1), .A1(A1), .Do1(u0_do1),
    .ERR0(u0_err0), .ERR1(u0_err1)
  );

  ram_dp_bwe #(.COLS(1), .WSIZE(4), .RD_PIPE(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .READY(u1_ready),
    .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(u1_do0),
    .EN1(EN1), .A1(A1), .Do1(u1_do1),
    .ERR0(u1_err0), .ERR1(u1_err1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc   = 0;
  int edges = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) edges <= 0;
    else        edges <= edges + 1;
  end

  typedef struct {
    logic [31:0] do0;
    logic [31:0] do1;
    logic        err0;
    logic        err1;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model [DEPTH];
  logic        bad   [DEPTH];
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [66:0] got, input logic [66:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic sb_chk(input string tag, input exp_t e, input logic [31:0] d0,
                        input logic [31:0] d1, input logic r0, input logic r1);
    n_vec++;
    if ({d0, d1, r0, r1} !== {e.do0, e.do1, e.err0, e.err1}) begin
      n_bad++;
      $display("FAIL sb_%s cyc=%0d got do0=%h do1=%h err=%b%b exp do0=%h do1=%h err=%b%b",
               tag, cyc, d0, d1, r0, r1, e.do0, e.do1, e.err0, e.err1);
    end else begin
      $display("txn %s cyc=%0d do0=%h do1=%h err=%b%b ok", tag, cyc, d0, d1, r0, r1);
    end
  endtask

  // Monitor: each instance's output is compared when its expected entry falls due.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      while (q0.size() > 0 && q0[0].due <= cyc) begin
        e = q0.pop_front();
        sb_chk("lat1", e, u0_do0, u0_do1, u0_err0, u0_err1);
      end
      while (q1.size() > 0 && q1[0].due <= cyc) begin
        e = q1.pop_front();
        sb_chk("lat2", e, u1_do0, u1_do1, u1_err0, u1_err1);
      end
    end
  end

  // Called just after a negedge; returns just after the following negedge.
  task automatic step(input logic en0, input logic [3:0] we0, input logic [7:0] a0,
                      input logic [31:0] di0, input logic en1, input logic [7:0] a1);
    exp_t e;
    e.do0 = 32'h0; e.do1 = 32'h0; e.err0 = 1'b0; e.err1 = 1'b0; e.due = 0;
    if (edges >= DEPTH) begin
      if (en0) begin e.do0 = model[a0]; e.err0 = bad[a0]; end
      if (en1) begin e.do1 = model[a1]; e.err1 = bad[a1]; end
      if (en0) begin
        for (int b = 0; b < 4; b++)
          if (we0[b]) model[a0][8*b +: 8] = di0[8*b +: 8];
        if (we0[0]) bad[a0] = 1'b0;
      end
    end
    e.due = cyc + 1; q0.push_back(e);
    e.due = cyc + 2; q1.push_back(e);
    EN0 = en0; WE0 = we0; A0 = a0; Di0 = di0; EN1 = en1; A1 = a1;
    @(posedge CLK);
    @(negedge CLK);
    chk("ready_lat1", 67'(u0_ready), 67'(edges >= DEPTH));
    chk("ready_lat2", 67'(u1_ready), 67'(edges >= DEPTH));
  endtask

  function automatic logic [7:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(64, 255));
    return 8'($urandom_range(0, 15));
  endfunction

  task automatic rnd_step();
    step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), rnd_addr(), $urandom(),
         $urandom_range(0, 1) == 1, rnd_addr());
  endtask

  task automatic idle_inputs();
    EN0 = 1'b0; WE0 = 4'h0; A0 = 8'h0; Di0 = 32'h0; EN1 = 1'b0; A1 = 8'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b0;
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin model[i] = 32'h0; bad[i] = 1'b0; end
    repeat (3) @(negedge CLK);
    chk("reset_lat1", {u0_ready, u0_do0, u0_do1, u0_err0, u0_err1}, 67'h0);
    chk("reset_lat2", {u1_ready, u1_do0, u1_do1, u1_err0, u1_err1}, 67'h0);

    // Clear sweep with random accesses that must be ignored.
    RST_N = 1'b1;
    for (int k = 0; k < DEPTH; k++) rnd_step();

    // Full write, read-back, partial byte write.
    step(1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1'b0, 8'h00);
    step(1'b1, 4'h0, 8'h10, 32'h0,        1'b0, 8'h00);
    step(1'b1, 4'h2, 8'h10, 32'h0000AA00, 1'b0, 8'h00);
    step(1'b1, 4'h0, 8'h10, 32'h0,        1'b1, 8'h10);

    // Same-edge write/read collision.
    step(1'b1, 4'hF, 8'h20, 32'h11111111, 1'b0, 8'h00);
    step(1'b1, 4'hF, 8'h20, 32'h22222222, 1'b1, 8'h20);
    step(1'b0, 4'h0, 8'h00, 32'h0,        1'b1, 8'h20);

    // Back-to-back reads, then a disabled cycle.
    step(1'b1, 4'hF, 8'h01, 32'hA5A5_0001, 1'b0, 8'h00);
    step(1'b1, 4'hF, 8'h02, 32'h5A5A_0002, 1'b0, 8'h00);
    step(1'b1, 4'h0, 8'h01, 32'h0, 1'b0, 8'h00);
    step(1'b1, 4'h0, 8'h02, 32'h0, 1'b0, 8'h00);
    step(1'b0, 4'hF, 8'h01, 32'hFFFF_FFFF, 1'b0, 8'h00);
    step(1'b1, 4'h0, 8'h01, 32'h0, 1'b1, 8'h02);

    for (int k = 0; k < 400; k++) rnd_step();

`ifdef RAM256_PARITY_EN
    step(1'b1, 4'hF, 8'h30, 32'hCAFEF00D, 1'b0, 8'h00);
    dut0.mem_q[8'h30][5] = ~dut0.mem_q[8'h30][5];
    dut1.mem_q[8'h30][5] = ~dut1.mem_q[8'h30][5];
    model[8'h30][5] = ~model[8'h30][5];
    bad[8'h30] = 1'b1;
    step(1'b1, 4'h0, 8'h30, 32'h0, 1'b1, 8'h30);
    step(1'b1, 4'hF, 8'h30, 32'h12345678, 1'b0, 8'h00);
    step(1'b1, 4'h0, 8'h30, 32'h0, 1'b1, 8'h30);
`endif

    // Let the scoreboard drain, then reset in the middle of a read.
    idle_inputs();
    repeat (3) @(negedge CLK);
    EN0 = 1'b1; A0 = 8'h10; EN1 = 1'b1; A1 = 8'h10;
    @(posedge CLK);
    #2;
    chk("pre_reset_do0", 67'(u0_do0), 67'(model[8'h10]));
    RST_N = 1'b0;
    #1;
    chk("midrst_lat1", {u0_ready, u0_do0, u0_do1, u0_err0, u0_err1}, 67'h0);
    chk("midrst_lat2", {u1_ready, u1_do0, u1_do1, u1_err0, u1_err1}, 67'h0);
    @(negedge CLK);
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin model[i] = 32'h0; bad[i] = 1'b0; end
    q0.delete();
    q1.delete();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < DEPTH; k++) rnd_step();
    step(1'b1, 4'h0, 8'h10, 32'h0, 1'b1, 8'h20);
    step(1'b1, 4'h0, 8'h01, 32'h0, 1'b1, 8'h10);
    for (int k = 0; k < 60; k++) rnd_step();

    idle_inputs();
    for (int i = 0; i < 6 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge CLK);
    chk("drain_left", 67'(q0.size() + q1.size()), 67'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
